custom_copy_engine: RTL and testbench

- Custom-logic initiator on the custom side of the endpoint-memory arbiter.
- Drives custom_rd_*/custom_wr_* and honours custom_en, which is low while the DMA owns the RAM.
- On a start pulse, copies len words from src_addr to dst_addr, one word at a time.
- Stalls transparently while the DMA has priority and reports completion with a done pulse.

---
 rtl/custom_copy_engine_pkg.sv | 7 +
 rtl/custom_copy_engine.sv | 90 +++++++++
 tb/tb_custom_copy_engine.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/custom_copy_engine_pkg.sv
// custom_copy_engine_pkg: shared RAM geometry, read latency and copy FSM states
package custom_copy_engine_pkg;
  localparam int DEF_W_ADDR = 12;
  localparam int DEF_W_DATA = 128;
  localparam int RD_LATENCY = 1;
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPT, WR, DONE} copy_state_t;
endpackage

// File: rtl/custom_copy_engine.sv
// custom_copy_engine: word-by-word RAM copier on the custom side of the endpoint-memory arbiter
//   clk, rst                  : clock, synchronous active-high reset
//   start, src_addr, dst_addr, len : job request, sampled only in IDLE
//   busy, done, words_done    : job status and one-cycle completion pulse
//   custom_en                 : arbiter grant, low while the DMA owns the RAM
//   custom_rd_* / custom_wr_* : RAM read (1-cycle latency) and write ports
//   checksum                  : XOR of committed words, only with COPY_CHECKSUM_EN defined
module custom_copy_engine
  import custom_copy_engine_pkg::*;
#(
  parameter int W_ADDR = DEF_W_ADDR,
  parameter int W_DATA = DEF_W_DATA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_ADDR-1:0] src_addr,
  input  logic [W_ADDR-1:0] dst_addr,
  input  logic [W_ADDR:0]   len,
  output logic              busy,
  output logic              done,
  output logic [W_ADDR:0]   words_done,
  input  logic              custom_en,
  output logic [W_ADDR-1:0] custom_rd_addr,
  output logic              custom_rd_en,
  input  logic [W_DATA-1:0] custom_rd_data,
  output logic [W_ADDR-1:0] custom_wr_addr,
  output logic [W_DATA-1:0] custom_wr_data,
  output logic              custom_wr_en
`ifdef COPY_CHECKSUM_EN
  ,
  output logic [W_DATA-1:0] checksum
`endif
);
  copy_state_t state, state_n;
  logic [W_ADDR-1:0] src_ptr, dst_ptr;
  logic [W_ADDR:0] len_q;
  logic [W_DATA-1:0] buf_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = !start ? IDLE : (len == '0 ? DONE : RD_ISSUE);
      RD_ISSUE: state_n = custom_en ? RD_CAPT : RD_ISSUE;
      RD_CAPT:  state_n = custom_en ? WR : RD_ISSUE;
      WR:       state_n = !custom_en ? WR : (words_done + 1'b1 == len_q ? DONE : RD_ISSUE);
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  assign busy           = state == RD_ISSUE || state == RD_CAPT || state == WR;
  assign done           = state == DONE;
  assign custom_rd_en   = state == RD_ISSUE || state == RD_CAPT;
  assign custom_rd_addr = src_ptr;
  assign custom_wr_en   = state == WR;
  assign custom_wr_addr = dst_ptr;
  assign custom_wr_data = buf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      len_q      <= '0;
      words_done <= '0;
      buf_q      <= '0;
`ifdef COPY_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        src_ptr    <= src_addr;
        dst_ptr    <= dst_addr;
        len_q      <= len;
        words_done <= '0;
`ifdef COPY_CHECKSUM_EN
        checksum   <= '0;
`endif
      end
      if (state == RD_CAPT && custom_en) buf_q <= custom_rd_data;
      if (state == WR && custom_en) begin
        src_ptr    <= src_ptr + 1'b1;
        dst_ptr    <= dst_ptr + 1'b1;
        words_done <= words_done + 1'b1;
`ifdef COPY_CHECKSUM_EN
        checksum   <= checksum ^ buf_q;
`endif
      end
    end
  end
endmodule

// File: tb/tb_custom_copy_engine.sv
// tb_custom_copy_engine: randomized self-checking bench with a RAM model and forward-copy reference
module tb_custom_copy_engine;
  import custom_copy_engine_pkg::*;
  localparam int WA = DEF_W_ADDR;
  localparam int WD = DEF_W_DATA;
  localparam int DEPTH = 1 << WA;
  logic clk = 0, rst = 1, start = 0, custom_en = 1;
  logic [WA-1:0] src_addr = '0, dst_addr = '0;
  logic [WA:0] len = '0;
  logic busy, done, custom_rd_en, custom_wr_en;
  logic [WA:0] words_done;
  logic [WA-1:0] custom_rd_addr, custom_wr_addr;
  logic [WD-1:0] custom_rd_data = '0, custom_wr_data;
`ifdef COPY_CHECKSUM_EN
  logic [WD-1:0] checksum;
`endif
  logic pl_en = 0;
  logic [WA-1:0] pl_addr = '0;
  logic [WD-1:0] pl_data = '0;
  logic [WD-1:0] mem [DEPTH];
  logic [WD-1:0] ref_mem [DEPTH];
  int checks = 0, errors = 0;
  custom_copy_engine dut (
`ifdef COPY_CHECKSUM_EN
    .checksum(checksum),
`endif
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .words_done(words_done), .custom_en(custom_en),
    .custom_rd_addr(custom_rd_addr), .custom_rd_en(custom_rd_en), .custom_rd_data(custom_rd_data),
    .custom_wr_addr(custom_wr_addr), .custom_wr_data(custom_wr_data), .custom_wr_en(custom_wr_en)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (custom_wr_en && custom_en) mem[custom_wr_addr] <= custom_wr_data;
    custom_rd_data <= (custom_rd_en && custom_en) ? mem[custom_rd_addr] : {$urandom, $urandom, $urandom, $urandom};
  end
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic preload(input logic [WA-1:0] a, input logic [WD-1:0] v);
    @(negedge clk);
    pl_en = 1;
    pl_addr = a;
    pl_data = v;
    ref_mem[a] = v;
    @(posedge clk);
    #1 pl_en = 0;
  endtask
  function automatic logic en_for(input int mode, input int c);
    if (mode == 1) return !(c == 5 || c == 6);
    if (mode == 2) return !(c >= 6 && c <= 8);
    if (mode == 3) return $urandom_range(0, 3) != 0;
    return 1'b1;
  endfunction
  task automatic run_job(input logic [WA-1:0] s, input logic [WA-1:0] d, input int n, input int mode, input int abort_after);
    int c, commits, rd_cyc, wr_cyc, done_c, nexp, bad, ndone;
    logic aborted;
    logic [WD-1:0] xs;
    nexp = (abort_after > 0 && abort_after < n) ? abort_after : n;
    xs = '0;
    for (int k = 0; k < nexp; k++) begin
      ref_mem[WA'(d + k)] = ref_mem[WA'(s + k)];
      xs ^= ref_mem[WA'(d + k)];
    end
    @(negedge clk);
    start = 1;
    src_addr = s;
    dst_addr = d;
    len = (WA + 1)'(n);
    custom_en = 1;
    c = 0; commits = 0; rd_cyc = 0; wr_cyc = 0; done_c = -1; aborted = 0;
    while (done_c < 0 && !aborted && c < 5000) begin
      @(negedge clk);
      start = $urandom_range(0, 1);
      c++;
      custom_en = en_for(mode, c);
      if (c == 1) check("busy_after_start", busy, n != 0);
      if (custom_rd_en && custom_wr_en) check("rd_wr_exclusive", 1, 0);
      if (custom_rd_en) begin
        rd_cyc++;
        check("rd_addr", custom_rd_addr, WA'(s + commits));
      end
      if (custom_wr_en) begin
        wr_cyc++;
        check("wr_addr", custom_wr_addr, WA'(d + commits));
        check("wr_data", custom_wr_data, ref_mem[WA'(d + commits)]);
        if (custom_en) commits++;
      end
      if (done) done_c = c;
      if (abort_after > 0 && commits == abort_after) aborted = 1;
    end
    start = 0;
    if (aborted) begin
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("rst_outputs", {busy, done, words_done, custom_rd_en, custom_wr_en, custom_rd_addr, custom_wr_addr, custom_wr_data}, 0);
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (done || busy || custom_rd_en || custom_wr_en) ndone++;
      end
      check("idle_after_rst", ndone, 0);
    end else begin
      check("done_seen", done_c >= 0, 1);
      if (mode < 3) check("done_cycle", done_c, 3 * n + 1 + (mode != 0 ? 3 : 0));
      check("words_done", words_done, n);
      check("commits", commits, n);
      if (mode == 0) check("rd_cycles", rd_cyc, 2 * n);
      if (mode == 0) check("wr_cycles", wr_cyc, n);
`ifdef COPY_CHECKSUM_EN
      check("checksum", checksum, xs);
`endif
      @(negedge clk);
      check("done_pulse_end", {done, busy}, 0);
    end
    bad = 0;
    for (int k = 0; k < nexp; k++)
      if (mem[WA'(d + k)] !== ref_mem[WA'(d + k)]) bad++;
    check("dst_mem", bad, 0);
  endtask
  initial begin
    int s, d, n;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, words_done, custom_rd_en, custom_wr_en, custom_rd_addr, custom_wr_addr, custom_wr_data}, 0);
    rst = 0;
    for (int k = 0; k < 4; k++) preload(WA'(12'h010 + k), {$urandom, $urandom, $urandom, $urandom});
    run_job(12'h010, 12'h100, 4, 0, 0);
    run_job(12'h020, 12'h200, 0, 0, 0);
    for (int k = 0; k < 4; k++) preload(WA'(12'h030 + k), {$urandom, $urandom, $urandom, $urandom});
    run_job(12'h030, 12'h300, 4, 1, 0);
    for (int k = 0; k < 4; k++) preload(WA'(12'h040 + k), {$urandom, $urandom, $urandom, $urandom});
    run_job(12'h040, 12'h400, 4, 2, 0);
    for (int k = 0; k < 4; k++) preload(WA'(12'hFFE + k), {$urandom, $urandom, $urandom, $urandom});
    run_job(12'hFFE, 12'h500, 4, 0, 0);
    run_job(12'hFFE, 12'h600, 4, 0, 2);
    run_job(12'h010, 12'h700, 4, 0, 0);
    for (int k = 0; k < 4; k++) preload(WA'(12'h050 + k), WD'(1 << k));
    run_job(12'h050, 12'h800, 4, 0, 0);
`ifdef COPY_CHECKSUM_EN
    check("checksum_1248", checksum, 'hF);
`endif
    for (int j = 0; j < 6; j++) begin
      s = $urandom_range(0, DEPTH - 1);
      d = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 16);
      for (int k = 0; k < n; k++) preload(WA'(s + k), {$urandom, $urandom, $urandom, $urandom});
      run_job(WA'(s), WA'(d), n, 3, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
